mat_scalar_seq: RTL

Sequencer for the matrix-by-scalar operation. It streams every element of an N×N int8 matrix out of a synchronous-read buffer, one element per cycle, and multiplies each by a latched signed scalar through the saturating 8-bit multiplier. It writes each saturated product back to a result buffer. It sits between the HPS-facing command/register logic, which supplies `start` and `scalar`, and the matrix memories.

---
 rtl/mat_pkg.sv | 21 ++
 rtl/mul8bc2_escalar.sv | 35 +++
 rtl/mat_scalar_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// mat_pkg
// Shared definitions for the matrix sequencer blocks: element width,
// largest supported matrix dimension, int8 saturation limits and the
// sequencer state encoding.
// No ports (package).
package mat_pkg;

  localparam int ELEM_W = 8;
  localparam int MAX_N  = 8;

  localparam logic signed [ELEM_W-1:0] INT8_MAX = 8'sh7F;
  localparam logic signed [ELEM_W-1:0] INT8_MIN = 8'sh80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mul8bc2_escalar.sv
// mul8bc2_escalar
// Combinational saturating signed 8-bit multiplier. Forms the full
// 16-bit signed product and clamps it to the int8 range.
// Ports:
//   a, b      in  8  signed two's-complement operands
//   result    out 8  product clamped to [-128, 127]
//   overflow  out 1  high when the clamp was applied
module mul8bc2_escalar
  import mat_pkg::*;
(
  input  logic signed [ELEM_W-1:0] a,
  input  logic signed [ELEM_W-1:0] b,
  output logic signed [ELEM_W-1:0] result,
  output logic                     overflow
);

  localparam logic signed [2*ELEM_W-1:0] P_MAX = 16'sd127;
  localparam logic signed [2*ELEM_W-1:0] P_MIN = -16'sd128;

  logic signed [2*ELEM_W-1:0] product;

  always_comb begin
    product  = a * b;
    result   = product[ELEM_W-1:0];
    overflow = 1'b0;
    if (product > P_MAX) begin
      result   = INT8_MAX;
      overflow = 1'b1;
    end else if (product < P_MIN) begin
      result   = INT8_MIN;
      overflow = 1'b1;
    end
  end

endmodule

// File: rtl/mat_scalar_seq.sv
// mat_scalar_seq
// Matrix-by-scalar sequencer. Streams the M = N*N int8 elements of the
// source buffer (synchronous read, one cycle latency), multiplies each by
// the scalar latched on start through a saturating multiplier, and writes
// the products to the result buffer at the same address.
// Optional feature macro: MAT_SCALAR_SAT_COUNT_EN adds the sat_count output.
// Parameters: N (matrix dimension, 1..8), AW (address width, 2^AW >= N*N).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, scalar       operation request (sampled in IDLE) and its scalar
//   rd_en, rd_addr      source buffer read strobe / address
//   rd_data             source element, valid one cycle after rd_en
//   wr_en, wr_addr      result buffer write strobe / address
//   wr_data             saturated product
//   busy, done          run in progress / one-cycle completion pulse
//   overflow            sticky saturation flag for the current or last run
//   sat_count           (macro only) saturated elements in the current run
module mat_scalar_seq
  import mat_pkg::*;
#(
  parameter int N  = 5,
  parameter int AW = 6
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ELEM_W-1:0] scalar,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [ELEM_W-1:0] rd_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [ELEM_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef MAT_SCALAR_SAT_COUNT_EN
  ,
  output logic [$clog2(N*N+1)-1:0] sat_count
`endif
);

  localparam int M = N * N;
  localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]               state;
  logic signed [ELEM_W-1:0] scalar_q;
  logic                     drain_cnt;
  logic                     accept;

  logic                     s1_valid;
  logic [AW-1:0]            s1_addr;

  logic signed [ELEM_W-1:0] mul_res;
  logic                     mul_ovf;

  assign accept = (state == S_IDLE) && start;

  // rd_addr doubles as the element counter; it holds at M-1 once the last
  // read has been issued so it never leaves the valid address range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      scalar_q  <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            scalar_q <= scalar;
            rd_en    <= 1'b1;
            rd_addr  <= '0;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (rd_addr == LAST_ADDR) begin
            rd_en     <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        // Two cycles let the last element pass through both pipeline stages.
        S_DRAIN: begin
          if (drain_cnt) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  mul8bc2_escalar u_mul (
    .a        ($signed(rd_data)),
    .b        (scalar_q),
    .result   (mul_res),
    .overflow (mul_ovf)
  );

  // Stage 1 tracks the read so rd_data arrives with its strobe and address;
  // stage 2 registers the saturated product as the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      overflow <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      s1_addr  <= rd_addr;
      wr_en    <= s1_valid;
      if (s1_valid) begin
        wr_addr <= s1_addr;
        wr_data <= mul_res;
      end
      if (accept) begin
        overflow <= 1'b0;
      end else if (s1_valid && mul_ovf) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef MAT_SCALAR_SAT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (accept) begin
      sat_count <= '0;
    end else if (s1_valid && mul_ovf) begin
      sat_count <= sat_count + 1'b1;
    end
  end
`endif

endmodule
